// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register file.
// Holds the completer FSM state encoding and the default word geometry.
package apb_pkg;

   typedef enum logic {
      APB_C_IDLE,
      APB_C_ACCESS
   } apb_c_state_e;

   localparam int APB_WORD_LSB = 2;
   localparam int APB_DATA_W   = 32;

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter for the APB completer.
// Counts ACCESS cycles up to LIMIT and raises done once the limit is reached.
module apb_wait_ctr #(
   parameter int LIMIT = 1
) (
   input  logic pclk,
   input  logic preset,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Saturates at LIMIT so done stays high until the next clear.
   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (en && !done) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign done = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/apb_completer_regfile.sv
// APB3 completer with NUM_REGS read/write registers and a read-only count of committed writes.
// Inserts WAIT_CYCLES wait states per transfer and flags PSLVERR on unmapped or read-only writes.
module apb_completer_regfile
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = APB_DATA_W,
   parameter int NUM_REGS    = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic              pready,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr
);

   localparam int IDX_W  = ADDR_W - APB_WORD_LSB;
   localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS);

   apb_c_state_e state_reg;
   apb_c_state_e state_next;

   logic              ctr_clr;
   logic              ctr_en;
   logic              ctr_done;

   logic [IDX_W-1:0]  idx;
   logic [RIDX_W-1:0] reg_idx;
   logic              is_reg;
   logic              is_cnt;
   logic              unmapped;
   logic              wr_commit;
   logic [NUM_REGS-1:0] wr_sel;

   logic [DATA_W-1:0] regs_reg [NUM_REGS];
   logic [DATA_W-1:0] wr_count_reg;

   // Byte-lane bits of the address carry no meaning for word registers.
   logic unused_addr_bits;
   assign unused_addr_bits = ^paddr[APB_WORD_LSB-1:0];

   apb_wait_ctr #(
      .LIMIT (WAIT_CYCLES)
   ) u_wait_ctr (
      .pclk   (pclk),
      .preset (preset),
      .clr    (ctr_clr),
      .en     (ctr_en),
      .done   (ctr_done)
   );

   always_comb begin
      state_next = state_reg;
      ctr_clr    = 1'b0;
      ctr_en     = 1'b0;
      case (state_reg)
         APB_C_IDLE: begin
            // An access phase without a preceding setup is ignored.
            if (psel && !penable) begin
               state_next = APB_C_ACCESS;
               ctr_clr    = 1'b1;
            end
         end
         APB_C_ACCESS: begin
            if (!psel) begin
               state_next = APB_C_IDLE;
            end else if (penable) begin
               if (ctr_done) begin
                  state_next = APB_C_IDLE;
               end else begin
                  ctr_en = 1'b1;
               end
            end
         end
         default: state_next = APB_C_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_reg <= APB_C_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   assign idx      = paddr[ADDR_W-1:APB_WORD_LSB];
   assign reg_idx  = idx[RIDX_W-1:0];
   assign is_reg   = (idx < CNT_IDX);
   assign is_cnt   = (idx == CNT_IDX);
   assign unmapped = !is_reg && !is_cnt;

   assign pready    = (state_reg == APB_C_ACCESS) && psel && penable && ctr_done;
   assign pslverr   = pready && (unmapped || (pwrite && is_cnt));
   assign wr_commit = pready && pwrite && !pslverr;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_commit && (idx == IDX_W'(gi));
      end
   endgenerate

   // Reset has priority, so a write completing in the reset cycle is dropped.
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
         wr_count_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               regs_reg[i] <= pwdata;
            end
         end
         if (wr_commit) begin
            wr_count_reg <= wr_count_reg + DATA_W'(1);
         end
      end
   end

   always_comb begin
      prdata = '0;
      if (pready && !pwrite) begin
         if (is_reg) begin
            prdata = regs_reg[reg_idx];
         end else if (is_cnt) begin
            prdata = wr_count_reg;
         end
      end
   end

endmodule
